// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - EX-stage ALU with iterative multiply/divide and HI/LO registers
//
// Decodes alu_ct_op/funct, executes single-cycle arithmetic/logic ops in one
// cycle and MULT/MULTU/DIV/DIVU iteratively over WIDTH cycles into HI/LO.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready operation handshake (in_ready = !busy)
//   alu_ct_op, funct  operation select
//   src_a, src_b      operands (dividend/multiplicand, divisor/multiplier)
//   out_valid         one-cycle pulse, result and flags valid
//   result            registered result
//   zero, illegal, div_by_zero  result flags, qualified by out_valid
//   busy              multi-cycle operation in progress

module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_ct_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_result;
  logic               r_out_valid;
  logic               r_zero;
  logic               r_illegal;
  logic               r_div_by_zero;

  // Multiply: {partial product high part (WIDTH+1), remaining multiplier bits (WIDTH)}
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  // Divide: restoring remainder, quotient (doubles as dividend shift register), divisor
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_res;   // signs differ: negate product / quotient
  logic               r_neg_rem;   // dividend negative: negate remainder
  logic               r_dbz;

  op_e                w_op;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_last;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_acc_next;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign busy        = (r_state != S_IDLE);
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign illegal     = r_illegal;
  assign div_by_zero = r_div_by_zero;

  always_comb begin
    w_op = OP_ILL;
    case (alu_ct_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100001: w_op = OP_ADD;
          6'b100011: w_op = OP_SUB;
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100110: w_op = OP_XOR;
          6'b100111: w_op = OP_NOR;
          6'b101010: w_op = OP_SLT;
          6'b101011: w_op = OP_SLTU;
          6'b010000: w_op = OP_MFHI;
          6'b010010: w_op = OP_MFLO;
          6'b011000: w_op = OP_MULT;
          6'b011001: w_op = OP_MULTU;
          6'b011010: w_op = OP_DIV;
          6'b011011: w_op = OP_DIVU;
          default:   w_op = OP_ILL;
        endcase
      end
      default: w_op = OP_ILL;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = src_a + src_b;
      OP_SUB:  w_alu_res = src_a - src_b;
      OP_AND:  w_alu_res = src_a & src_b;
      OP_OR:   w_alu_res = src_a | src_b;
      OP_XOR:  w_alu_res = src_a ^ src_b;
      OP_NOR:  w_alu_res = ~(src_a | src_b);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_neg_a  = w_signed & src_a[WIDTH-1];
  assign w_neg_b  = w_signed & src_b[WIDTH-1];
  // Unsigned magnitudes: -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign w_mag_a  = w_neg_a ? (~src_a + 1'b1) : src_a;
  assign w_mag_b  = w_neg_b ? (~src_b + 1'b1) : src_b;
  assign w_last   = (r_cnt == CW'(1));

  // Shift-add step: add multiplicand to the high part if the current multiplier bit is set, shift right
  assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
  assign w_acc_next = r_acc[0] ? {1'b0, w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH:1]};
  assign w_prod_mag = w_acc_next[2*WIDTH-1:0];
  assign w_prod     = r_neg_res ? (~w_prod_mag + 1'b1) : w_prod_mag;

  // Restoring step; the remainder stays below the divisor, so the difference sign bit is the borrow
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  // With a zero divisor the remainder path reconstructs src_a exactly, so only LO needs forcing
  assign w_quo_fix  = r_dbz ? '1 : (r_neg_res ? (~w_quo_next + 1'b1) : w_quo_next);
  assign w_rem_fix  = r_neg_rem ? (~w_rem_next + 1'b1) : w_rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_result      <= '0;
      r_out_valid   <= 1'b0;
      r_zero        <= 1'b0;
      r_illegal     <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_neg_res     <= 1'b0;
      r_neg_rem     <= 1'b0;
      r_dbz         <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_zero        <= 1'b0;
      r_illegal     <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_mul) begin
              r_state   <= S_MUL;
              r_cnt     <= CW'(WIDTH);
              r_mcand   <= w_mag_a;
              r_acc     <= {{(WIDTH+1){1'b0}}, w_mag_b};
              r_neg_res <= w_neg_a ^ w_neg_b;
            end else if (w_is_div) begin
              r_state   <= S_DIV;
              r_cnt     <= CW'(WIDTH);
              r_rem     <= '0;
              r_quo     <= w_mag_a;
              r_divisor <= w_mag_b;
              r_neg_res <= w_neg_a ^ w_neg_b;
              r_neg_rem <= w_neg_a;
              r_dbz     <= (src_b == '0);
            end else begin
              r_result    <= w_alu_res;
              r_out_valid <= 1'b1;
              r_zero      <= (w_alu_res == '0);
              r_illegal   <= (w_op == OP_ILL);
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_hi        <= w_prod[2*WIDTH-1:WIDTH];
            r_lo        <= w_prod[WIDTH-1:0];
            r_result    <= w_prod[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_zero      <= (w_prod[WIDTH-1:0] == '0);
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (w_last) begin
            r_hi          <= w_rem_fix;
            r_lo          <= w_quo_fix;
            r_result      <= w_quo_fix;
            r_out_valid   <= 1'b1;
            r_zero        <= (w_quo_fix == '0);
            r_div_by_zero <= r_dbz;
            r_cnt         <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - self-checking bench for alu_muldiv_unit

module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    alu_ct_op = 2'b00;
  logic [5:0]    funct = 6'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;
  logic          div_by_zero;
  logic          busy;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ct_op(alu_ct_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vecs[15];
  logic [5:0] flist[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural meaning of each op using native 32/64-bit arithmetic
  function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output logic dbz,
                                output logic multi, output logic [31:0] nhi, output logic [31:0] nlo);
    longint p;
    longint unsigned pu;
    int sa;
    int sb;
    res = '0; ill = 1'b0; dbz = 1'b0; multi = 1'b0; nhi = m_hi; nlo = m_lo;
    sa = a; sb = b;
    if (op == 2'b00) res = a + b;
    else if (op == 2'b01) res = a - b;
    else if (op == 2'b11) ill = 1'b1;
    else begin
      case (f)
        6'h21: res = a + b;
        6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2a: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2b: res = (a < b) ? 32'd1 : 32'd0;
        6'h10: res = m_hi;
        6'h12: res = m_lo;
        6'h18: begin multi = 1'b1; p = longint'(sa) * longint'(sb); {nhi, nlo} = p; end
        6'h19: begin multi = 1'b1; pu = {32'b0, a} * {32'b0, b}; {nhi, nlo} = pu; end
        6'h1a: begin
          multi = 1'b1;
          if (b == 0) begin dbz = 1'b1; nhi = a; nlo = 32'hFFFFFFFF; end
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin nlo = a; nhi = 0; end
          else begin nlo = sa / sb; nhi = sa % sb; end
        end
        6'h1b: begin
          multi = 1'b1;
          if (b == 0) begin dbz = 1'b1; nhi = a; nlo = 32'hFFFFFFFF; end
          else begin nlo = a / b; nhi = a % b; end
        end
        default: ill = 1'b1;
      endcase
    end
    if (multi) res = nlo;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 9));
      2: return 32'h80000000 | 32'($urandom_range(0, 3));
      default: return 32'hFFFFFFFF - 32'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic drive_garbage();
    alu_ct_op = 2'($urandom);
    funct     = 6'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
    in_valid  = 1'b1;
  endtask

  task automatic run_multi(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
    int n;
    int bad;
    alu_ct_op = 2'b10; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
    cyc();
    chk({name, " no out_valid at accept"}, {31'b0, out_valid}, 32'd0);
    n = 0;
    bad = 0;
    drive_garbage();
    while (n < 40) begin
      cyc();
      n++;
      if (out_valid === 1'b1) break;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      if (n <= 30) drive_garbage();
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({name, " busy/in_ready cycles wrong"}, bad, 0);
    chk({name, " latency"}, n, 32);
    chk({name, " result"}, result, exp_lo);
    chk({name, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
    chk({name, " zero"}, {31'b0, zero}, {31'b0, (exp_lo == 0)});
    chk({name, " illegal"}, {31'b0, illegal}, 32'd0);
    chk({name, " in_ready at done"}, {31'b0, in_ready}, 32'd1);
    m_hi = exp_hi;
    m_lo = exp_lo;
    alu_ct_op = 2'b10; funct = 6'h10; in_valid = 1'b1;
    cyc();
    chk({name, " MFHI"}, result, exp_hi);
    chk({name, " MFHI out_valid"}, {31'b0, out_valid}, 32'd1);
    funct = 6'h12;
    cyc();
    chk({name, " MFLO"}, result, exp_lo);
    in_valid = 1'b0;
    cyc();
    chk({name, " out_valid drops"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_res;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_ill;
    logic        e_dbz;
    logic        e_multi;
    int          sel;
    int          stray;

    vecs[0]  = '{2'b10, 6'h21, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[1]  = '{2'b10, 6'h2a, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b10, 6'h2a, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{2'b10, 6'h2b, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{2'b10, 6'h2b, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[5]  = '{2'b00, 6'h3f, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0};
    vecs[6]  = '{2'b01, 6'h00, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
    vecs[7]  = '{2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[8]  = '{2'b10, 6'h25, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
    vecs[9]  = '{2'b10, 6'h26, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[10] = '{2'b10, 6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{2'b10, 6'h23, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};
    vecs[12] = '{2'b10, 6'h00, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[13] = '{2'b11, 6'h21, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1};
    vecs[14] = '{2'b10, 6'h10, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

    flist = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h10, 6'h12};

    repeat (3) cyc();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset result", result, 32'd0);
    chk("reset flags", {29'b0, zero, illegal, div_by_zero}, 32'd0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 15; i++) begin
      alu_ct_op = vecs[i].op; funct = vecs[i].f; src_a = vecs[i].a; src_b = vecs[i].b;
      in_valid = 1'b1;
      cyc();
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d zero", i), {31'b0, zero}, {31'b0, (vecs[i].res == 0)});
      chk($sformatf("vec%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
      chk($sformatf("vec%0d div_by_zero", i), {31'b0, div_by_zero}, 32'd0);
    end
    in_valid = 1'b0;
    cyc();
    chk("idle out_valid", {31'b0, out_valid}, 32'd0);

    run_multi("mult -3*7", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_multi("div -7/2", 6'h1a, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_multi("divu 100/7", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_multi("divu 5/0", 6'h1b, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    run_multi("div -7/0", 6'h1a, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_multi("mult min*min", 6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_multi("div min/-1", 6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_multi("multu max*max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = rnd_operand();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_operand();
      model(2'b10, f, a, b, e_res, e_ill, e_dbz, e_multi, e_hi, e_lo);
      run_multi($sformatf("rand multi %0d f=%h a=%h b=%h", i, f, a, b), f, a, b, e_hi, e_lo, e_dbz);
    end

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 13);
      case (sel)
        0: begin op = 2'b00; f = 6'($urandom); end
        1: begin op = 2'b01; f = 6'($urandom); end
        2: begin op = 2'b11; f = 6'($urandom); end
        3: begin op = 2'b10; f = 6'($urandom_range(0, 15)); end
        default: begin op = 2'b10; f = flist[sel-4]; end
      endcase
      a = rnd_operand();
      b = rnd_operand();
      model(op, f, a, b, e_res, e_ill, e_dbz, e_multi, e_hi, e_lo);
      alu_ct_op = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
      cyc();
      chk($sformatf("rand single %0d op=%b f=%h out_valid", i, op, f), {31'b0, out_valid}, 32'd1);
      chk($sformatf("rand single %0d op=%b f=%h a=%h b=%h result", i, op, f, a, b), result, e_res);
      chk($sformatf("rand single %0d flags", i), {29'b0, zero, illegal, div_by_zero},
          {29'b0, (e_res == 0), e_ill, 1'b0});
    end
    in_valid = 1'b0;
    cyc();

    alu_ct_op = 2'b10; funct = 6'h1a; src_a = 32'd1234567; src_b = 32'd89; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (9) cyc();
    chk("mid-div busy before reset", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy}, 32'd0);
    chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset flags", {29'b0, zero, illegal, div_by_zero}, 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    chk("stray out_valid after reset", stray, 0);
    alu_ct_op = 2'b10; funct = 6'h12; in_valid = 1'b1;
    cyc();
    chk("MFLO after reset", result, 32'd0);
    chk("MFLO after reset out_valid", {31'b0, out_valid}, 32'd1);
    funct = 6'h10;
    cyc();
    chk("MFHI after reset", result, 32'd0);
    chk("MFHI after reset zero", {31'b0, zero}, 32'd1);
    in_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
